// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: IDLE/ACCESS/RESP per access.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (A wins ties); default is round-robin.
module data_memory_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_d;
  logic                cmd_we;
  logic                cmd_b;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                grant_b;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign grant_b = ~a_req;
`else
  logic last_b;

  // B only wins a tie when A was granted last
  assign grant_b = b_req & (~a_req | ~last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (state == IDLE && (a_req || b_req)) begin
      last_b <= grant_b;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (a_req || b_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, command latch, response and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_b     <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      a_ack <= (state == ACCESS) && !cmd_b;
      b_ack <= (state == ACCESS) && cmd_b;
      if (state == IDLE && (a_req || b_req)) begin
        cmd_b     <= grant_b;
        cmd_we    <= grant_b ? b_we    : a_we;
        cmd_addr  <= grant_b ? b_addr  : a_addr;
        cmd_wdata <= grant_b ? b_wdata : a_wdata;
      end
      if (state == ACCESS && !cmd_we) begin
        if (cmd_b) b_rdata <= mem_data;
        else       a_rdata <= mem_data;
      end
    end
  end

  // Command registers only change when leaving IDLE, so the bus holds outside ACCESS
  assign mem_address    = cmd_addr;
  assign mem_write_data = cmd_wdata;
  // Strobes gated by rst so a reset landing in ACCESS kills the write at that edge
  assign mem_write      = (state == ACCESS) && cmd_we  && !rst;
  assign mem_read       = (state == ACCESS) && !cmd_we && !rst;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter with a behavioural data memory.
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] mem_address, mem_write_data, mem_data;
  logic       mem_write, mem_read, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic       is_b;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_a_hold = 8'h00;
  logic [7:0] exp_b_hold = 8'h00;

  data_memory_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data(mem_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[0] = 8'h0A; ref_mem[0] = 8'h0A;
    mem[2] = 8'h01; ref_mem[2] = 8'h01;
  end

  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
  assign mem_data = mem_read ? mem[mem_address] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Every ack is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (a_ack || b_ack)) begin
      check("ack_exclusive", 32'(a_ack && b_ack), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_owner", 32'(b_ack), 32'(e.is_b));
        check("ack_rdata", 32'(b_ack ? b_rdata : a_rdata), 32'(e.rdata));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic drive(input logic is_b, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (is_b) begin b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; end
  endtask

  // Uncontended access issued from an IDLE cycle; returns in the following IDLE cycle
  task automatic xact(input logic is_b, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    int         wr_n, rd_n;
    logic [7:0] expd;
    bit         done;
    wr_n = 0; rd_n = 0; done = 0;
    if (we) begin
      ref_mem[addr] = wdata;
      expd = is_b ? exp_b_hold : exp_a_hold;
    end else begin
      expd = ref_mem[addr];
      if (is_b) exp_b_hold = expd; else exp_a_hold = expd;
    end
    sb.push_back('{is_b, expd, cyc + 2});
    drive(is_b, 1'b1, we, addr, wdata);
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk); #1;
      if (mem_write) wr_n++;
      if (mem_read)  rd_n++;
      if (mem_write || mem_read) check("mem_address", 32'(mem_address), 32'(addr));
      if (mem_write) check("mem_write_data", 32'(mem_write_data), 32'(wdata));
      if (is_b ? b_ack : a_ack) done = 1;
    end
    check("ack_timeout", 32'(done), 32'd1);
    drive(is_b, 1'b0, 1'b0, 8'h00, 8'h00);
    check("write_cycles", 32'(wr_n), 32'(we));
    check("read_cycles", 32'(rd_n), 32'(!we));
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_b_ack", 32'(b_ack), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_write_data", 32'(mem_write_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Basic read, write, read-back
    xact(1'b0, 1'b0, 8'h00, 8'h00);
    xact(1'b1, 1'b1, 8'h05, 8'h3C);
    xact(1'b0, 1'b0, 8'h05, 8'h00);

    // Reset landing in the ACCESS cycle of a B write
    drive(1'b1, 1'b1, 1'b1, 8'h02, 8'hAA);
    @(negedge clk); #1;
    check("rstacc_write_pre", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rstacc_write_gated", 32'(mem_write), 32'd0);
    @(negedge clk); #1;
    check("rstacc_b_ack", 32'(b_ack), 32'd0);
    check("rstacc_busy", 32'(busy), 32'd0);
    check("rstacc_b_rdata", 32'(b_rdata), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    exp_a_hold = 8'h00;
    exp_b_hold = 8'h00;
    @(negedge clk); #1;
    xact(1'b1, 1'b0, 8'h02, 8'h00);

    // Both requesters held for 12 cycles
    c0 = cyc;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h05, 8'h00);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 8'h0A, c0 + 2 + 3 * k});
    exp_a_hold = 8'h0A;
`else
    for (int k = 0; k < 4; k++)
      sb.push_back('{k[0], (k[0] ? 8'h3C : 8'h0A), c0 + 2 + 3 * k});
    exp_a_hold = 8'h0A;
    exp_b_hold = 8'h3C;
`endif
    repeat (11) @(negedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); #1;
    check("fair_idle0", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("fair_idle1", 32'(busy), 32'd0);

    // A pulses for one cycle while B is in ACCESS
    c0 = cyc;
    ref_mem[8'h10] = 8'h07;
    sb.push_back('{1'b1, exp_b_hold, c0 + 2});
    drive(1'b1, 1'b1, 1'b1, 8'h10, 8'h07);
    @(negedge clk); #1;
    check("pulse_busy_access", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("pulse_a_ack_resp", 32'(a_ack), 32'd0);
    @(negedge clk); #1;
    check("pulse_busy_idle0", 32'(busy), 32'd0);
    check("pulse_a_ack_idle0", 32'(a_ack), 32'd0);
    @(negedge clk); #1;
    check("pulse_busy_idle1", 32'(busy), 32'd0);
    xact(1'b0, 1'b0, 8'h10, 8'h00);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, address width on every port.
REQ-002 Parameter: DATA_W, 8, data width on every port.
REQ-003 clk  in  1  Sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  Reset, synchronous and active-high.
REQ-005 a_req  in  1  Requester A (CPU load/store) access request.
REQ-006 a_we  in  1  Requester A direction: 1=write, 0=read.
REQ-007 a_addr  in  ADDR_W  Requester A address.
REQ-008 a_wdata  in  DATA_W  Requester A write data.
REQ-009 a_ack  out  1  One-cycle completion pulse to A.
REQ-010 a_rdata  out  DATA_W  Registered read data to A; valid while a_ack=1.
REQ-011 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  Requester B (DMA/debug); same directions, widths and meanings as REQ-005..010.
REQ-012 mem_address  out  ADDR_W  Data memory address.
REQ-013 mem_write_data  out  DATA_W  Data memory write data.
REQ-014 mem_write  out  1  Data memory write strobe; the memory writes on the clk edge ending a cycle with the strobe high.
REQ-015 mem_read  out  1  Data memory read enable; the memory returns 0 when low.
REQ-016 mem_data  in  DATA_W  Combinational read data from the data memory.
REQ-017 busy  out  1  High in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS and RESP. Transitions: IDLE->ACCESS on any sampled req; ACCESS->RESP always; RESP->IDLE always.
REQ-019 In IDLE with at least one req high, the winner's we, addr and wdata SHALL be latched into internal command registers at that edge.
REQ-020 Arbitration: if only one req is high, that requester wins. If both are high, the requester not granted last wins (round-robin).
REQ-021 In ACCESS, mem_address and mem_write_data SHALL come from the latched command. mem_write equals latched we, and mem_read equals its inverse.
REQ-022 In IDLE and RESP, mem_write and mem_read SHALL be 0, and mem_address and mem_write_data SHALL hold their last values.
REQ-023 On a read, mem_data SHALL be captured at the edge ending ACCESS into the winner's rdata register. Each rdata register holds until that requester's next read.
REQ-024 The winner's ack SHALL be high for exactly the RESP cycle. The other ack stays 0. The two acks are never high together.
REQ-025 Latency: req sampled at edge N, ACCESS in cycle N+1, ack in cycle N+2. Peak throughput is one access per 3 cycles.
REQ-026 Handshake: the requester holds req, we, addr and wdata stable until ack. A req still high in RESP is not sampled and is re-arbitrated in the following IDLE.
REQ-027 A requester that drops req before its grant is not served, and no ack is generated for it.
REQ-028 Addresses pass through unmodified at full ADDR_W. Wrap-around on unimplemented locations is the memory's responsibility.
REQ-029 Fairness: under continuous requests from both sides, grants SHALL strictly alternate A,B,A,B.

Reset
REQ-030 While rst=1 at an edge: state<=IDLE, last-grant<=B (A wins the first tie), command registers<=0, a_rdata and b_rdata<=0.
REQ-031 Output values while in reset: a_ack=0, b_ack=0, mem_write=0, mem_read=0, mem_address=0, mem_write_data=0, busy=0.
REQ-032 mem_write SHALL be gated by ~rst combinationally, so a reset asserted during ACCESS suppresses the write at that edge.
REQ-033 A reset asserted during ACCESS also produces no ack and no rdata update.

Configuration
REQ-034 Macro DMEM_ARB_FIXED_PRIO_EN, when defined: fixed priority with A always winning ties. The last-grant register is not implemented, and REQ-029 does not apply.
REQ-035 When DMEM_ARB_FIXED_PRIO_EN is undefined: round-robin per REQ-020 and REQ-029. The default build leaves it undefined.

Verification
REQ-036 Memory preloaded with loc0=0x0A. a_req=1, a_we=0, a_addr=0x00 -> mem_read=1 in cycle 1, a_ack=1 with a_rdata=0x0A in cycle 2, b_ack=0.
REQ-037 b_req=1, b_we=1, b_addr=0x05, b_wdata=0x3C -> mem_write=1 with mem_address=0x05 for exactly one cycle, b_ack in cycle 2. A subsequent A read of 0x05 returns 0x3C.
REQ-038 a_req and b_req both held high for 12 cycles, round-robin build -> 4 grants in order A,B,A,B, with acks at cycles 2,5,8,11. Fixed-priority build -> 4 grants, all to A.
REQ-039 rst asserted in the ACCESS cycle of a B write of 0xAA to 0x02 (loc2 held 0x01) -> no b_ack, busy=0 next cycle, and a later read of 0x02 returns 0x01.
REQ-040 a_req pulsed high for one cycle while B is in ACCESS -> A is not served, a_ack stays 0, and the FSM returns to IDLE after B's RESP.
